cellrv32_cpu_regfile_mp: RTL and testbench

CELLRV32_CPU_REGFILE_MP -- requirements
Module: cellrv32_cpu_regfile_mp

---
 rtl/cellrv32_cpu_regfile_pkg.sv | 11 +
 rtl/cellrv32_cpu_regfile_scoreboard.sv | 55 +++++
 rtl/cellrv32_cpu_regfile_mp.sv | 146 ++++++++++++++
 tb/tb_cellrv32_cpu_regfile_mp.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cellrv32_cpu_regfile_pkg.sv
// Shared types and constants for the multi-port register file and its pending-write scoreboard.
package cellrv32_cpu_regfile_pkg;

    localparam int rf_addr_width_c = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_clr_state_t;

endpackage

// File: rtl/cellrv32_cpu_regfile_scoreboard.sv
// Pending-write scoreboard: one bit per entry, set beats clear, bit 0 never pending.
module cellrv32_cpu_regfile_scoreboard
    import cellrv32_cpu_regfile_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic                              i_set_en,
    input  logic [rf_addr_width_c-1:0]        i_set_addr,
    input  logic                              i_clr_en,
    input  logic [rf_addr_width_c-1:0]        i_clr_addr,
    input  logic [rf_addr_width_c*NUM_RD-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]                 o_hazard
);

    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [AW-1:0]       w_set_idx;
    logic [AW-1:0]       w_clr_idx;

    assign w_set_idx = i_set_addr[AW-1:0];
    assign w_clr_idx = i_clr_addr[AW-1:0];

    // Clear is applied first so a same-address set overrides it.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_en) begin
            w_pending_nxt[w_clr_idx] = 1'b0;
        end
        if (i_set_en) begin
            w_pending_nxt[w_set_idx] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_hazard
            assign o_hazard[g] = r_pending[i_rd_addr[g*rf_addr_width_c +: AW]];
        end
    endgenerate

endmodule

// File: rtl/cellrv32_cpu_regfile_mp.sv
// Multi-port register file: clear-on-reset sequencer, primary and secondary write ports,
// synchronous reads with optional same-cycle forwarding, and a pending-write scoreboard.
module cellrv32_cpu_regfile_mp
    import cellrv32_cpu_regfile_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 2,
    parameter int BYPASS_EN = 1
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              wa_en_i,
    input  logic [rf_addr_width_c-1:0]        wa_addr_i,
    input  logic [XLEN-1:0]                   wa_data_i,
    input  logic                              wb_valid_i,
    input  logic [rf_addr_width_c-1:0]        wb_addr_i,
    input  logic [XLEN-1:0]                   wb_data_i,
    output logic                              wb_ready_o,
    input  logic                              sb_set_i,
    input  logic [rf_addr_width_c-1:0]        sb_addr_i,
    input  logic [rf_addr_width_c*NUM_RD-1:0] rd_addr_i,
    output logic [XLEN*NUM_RD-1:0]            rd_data_o,
    output logic [NUM_RD-1:0]                 hazard_o,
    output logic                              busy_o
);

    localparam int AW = $clog2(NUM_REGS);

    rf_clr_state_t r_state;
    rf_clr_state_t w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    logic          w_run;
    logic          w_wb_acc;
    logic          w_wa_we;
    logic          w_wb_we;
    logic [AW-1:0] w_wa_idx;
    logic [AW-1:0] w_wb_idx;

    logic [XLEN-1:0] r_mem     [NUM_REGS];
    logic [XLEN-1:0] r_rd_data [NUM_RD];
    logic [XLEN-1:0] w_rd_val  [NUM_RD];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == AW'(NUM_REGS - 1)) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Reset is folded in so ready drops and busy rises in the same cycle rstn_i falls.
    assign w_run      = rstn_i && (r_state == RUN);
    assign busy_o     = !w_run;
    assign wb_ready_o = w_run && !wa_en_i;
    assign w_wb_acc   = wb_valid_i && wb_ready_o;

    assign w_wa_idx = wa_addr_i[AW-1:0];
    assign w_wb_idx = wb_addr_i[AW-1:0];
    assign w_wa_we  = w_run && wa_en_i && (w_wa_idx != '0);
    assign w_wb_we  = w_wb_acc && (w_wb_idx != '0);

    always_ff @(posedge clk_i) begin
        if (r_state == CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wa_we) begin
            r_mem[w_wa_idx] <= wa_data_i;
        end else if (w_wb_we) begin
            r_mem[w_wb_idx] <= wb_data_i;
        end
    end

    always_comb begin
        logic [AW-1:0] v_idx;
        v_idx = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            v_idx = rd_addr_i[k*rf_addr_width_c +: AW];
            if (v_idx == '0) begin
                w_rd_val[k] = '0;
            end else if ((BYPASS_EN != 0) && w_wa_we && (w_wa_idx == v_idx)) begin
                w_rd_val[k] = wa_data_i;
            end else if ((BYPASS_EN != 0) && w_wb_we && (w_wb_idx == v_idx)) begin
                w_rd_val[k] = wb_data_i;
            end else begin
                w_rd_val[k] = r_mem[v_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_RD; k++) begin
            if (!w_run) begin
                r_rd_data[k] <= '0;
            end else begin
                r_rd_data[k] <= w_rd_val[k];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_rd_out
            assign rd_data_o[g*XLEN +: XLEN] = r_rd_data[g];
        end
    endgenerate

    cellrv32_cpu_regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .i_clk      (clk_i),
        .i_rstn     (rstn_i),
        .i_set_en   (w_run && sb_set_i),
        .i_set_addr (sb_addr_i),
        .i_clr_en   (w_wb_acc),
        .i_clr_addr (wb_addr_i),
        .i_rd_addr  (rd_addr_i),
        .o_hazard   (hazard_o)
    );

endmodule

// File: tb/tb_cellrv32_cpu_regfile_mp.sv
// Bench for the multi-port register file: a forwarding and a non-forwarding instance share stimulus.
module tb_cellrv32_cpu_regfile_mp;

    logic        clk = 1'b0;
    logic        rstn;
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [9:0]  rd_addr;

    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  hazard, hazard_nb;
    logic        wb_ready, wb_ready_nb;
    logic        busy, busy_nb;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_mem [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;
    vec_t vecs [8];

    cellrv32_cpu_regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS_EN(1)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_ready_o(wb_ready),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .hazard_o(hazard), .busy_o(busy)
    );

    cellrv32_cpu_regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .BYPASS_EN(0)) dut_nb (
        .clk_i(clk), .rstn_i(rstn),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_ready_o(wb_ready_nb),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .hazard_o(hazard_nb), .busy_o(busy_nb)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic sb_push(input logic [31:0] e0, input logic [31:0] e1);
        exp_q.push_back({e1, e0});
    endtask

    task automatic sb_pop(input string name);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            chk({name, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_p0"}, rd_data[31:0], e[31:0]);
            chk({name, "_p1"}, rd_data[63:32], e[63:32]);
        end
    endtask

    // Counts busy cycles from now while poking writes/sets that must be ignored.
    task automatic count_clear(output int n, output int bad);
        n = 0;
        bad = 0;
        #1;
        while (busy === 1'b1 && n < 100) begin
            if (wb_ready !== 1'b0 || rd_data !== 64'd0 || hazard !== 2'b00) bad++;
            wa_en = n[0]; wa_addr = 5'd4; wa_data = 32'h55;
            sb_set = 1'b1; sb_addr = 5'd4;
            wb_valid = ~n[0]; wb_addr = 5'd4; wb_data = 32'h66;
            n++;
            tick;
        end
        idle;
    endtask

    initial begin
        int n;
        int bad;
        logic we, wbv, acc, wb_hold;
        logic [4:0] wa, wba, r0, r1;
        logic [31:0] wd, wbd, e0, e1, n0, n1;

        vecs[0] = '{1'b1, 5'd1,  32'h11111111, 5'd1,  5'd2,  32'h11111111, 32'h00000000};
        vecs[1] = '{1'b1, 5'd2,  32'h22222222, 5'd1,  5'd2,  32'h11111111, 32'h22222222};
        vecs[2] = '{1'b1, 5'd1,  32'hAAAA5555, 5'd1,  5'd1,  32'hAAAA5555, 32'hAAAA5555};
        vecs[3] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd7,  32'hDEADBEEF, 32'h00001234};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFF0000, 5'd31, 5'd0,  32'hFFFF0000, 32'h00000000};
        vecs[5] = '{1'b1, 5'd2,  32'h00000000, 5'd2,  5'd31, 32'h00000000, 32'hFFFF0000};
        vecs[6] = '{1'b0, 5'd3,  32'h00000033, 5'd3,  5'd1,  32'h00000000, 32'hAAAA5555};
        vecs[7] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd9,  32'h00000000, 32'h00000099};

        // Reset held: busy, not ready, reads zero.
        idle;
        rd_addr = '0;
        rstn = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h77;
        tick; tick; tick;
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_wb_ready", 32'(wb_ready), 32'd0);
        chk("reset_rd_data", rd_data[31:0], 32'd0);
        idle;

        rstn = 1'b1;
        count_clear(n, bad);
        chk("clear_cycles", n, 32'd32);
        chk("clear_outputs_quiet", bad, 32'd0);
        chk("run_busy", 32'(busy), 32'd0);

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            sb_push(32'd0, 32'd0);
            tick;
            sb_pop("zero_read");
        end
        rd_addr = {5'd0, 5'd4};
        #1 chk("clear_ignored_sb_set", 32'(hazard[0]), 32'd0);

        // Same-cycle write and read of x5.
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd5};
        tick;
        chk("bypass_new", rd_data[31:0], 32'hDEADBEEF);
        chk("nobypass_old", rd_data_nb[31:0], 32'h0);
        idle;
        tick;
        chk("nobypass_later", rd_data_nb[31:0], 32'hDEADBEEF);
        chk("bypass_hold", rd_data[31:0], 32'hDEADBEEF);

        // Secondary write blocked while the primary port is busy.
        wa_en = 1'b1; wa_addr = 5'd10; wa_data = 32'hA;
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        rd_addr = {5'd0, 5'd7};
        for (int i = 0; i < 3; i++) begin
            #1 chk("wb_ready_blocked", 32'(wb_ready), 32'd0);
            tick;
        end
        chk("wb_not_yet_written", rd_data[31:0], 32'h0);
        wa_en = 1'b0;
        #1 chk("wb_ready_free", 32'(wb_ready), 32'd1);
        tick;
        chk("wb_bypass", rd_data[31:0], 32'h1234);
        idle;
        rd_addr = {5'd10, 5'd7};
        tick;
        chk("wb_x7", rd_data[31:0], 32'h1234);
        chk("wa_x10", rd_data[63:32], 32'hA);

        // Scoreboard set / clear priority.
        sb_set = 1'b1; sb_addr = 5'd9;
        tick;
        idle;
        rd_addr = {5'd9, 5'd9};
        #1 chk("hazard_set", 32'(hazard), 32'd3);
        sb_set = 1'b1; sb_addr = 5'd9;
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        #1 chk("wb_ready_set_clr", 32'(wb_ready), 32'd1);
        tick;
        idle;
        #1 chk("hazard_set_wins", 32'(hazard), 32'd3);
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        #1 chk("hazard_before_clr", 32'(hazard), 32'd3);
        tick;
        idle;
        #1 chk("hazard_cleared", 32'(hazard), 32'd0);

        // x0 stays zero and never pending.
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF;
        rd_addr = {5'd0, 5'd0};
        tick;
        chk("x0_wa_bypass", rd_data[31:0], 32'h0);
        idle;
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        sb_set = 1'b1; sb_addr = 5'd0;
        tick;
        idle;
        #1 chk("x0_hazard", 32'(hazard[0]), 32'd0);
        tick;
        chk("x0_read", rd_data[31:0], 32'h0);
        chk("x0_read_nb", rd_data_nb[31:0], 32'h0);

        for (int i = 0; i < 8; i++) begin
            wa_en = vecs[i].we; wa_addr = vecs[i].wa; wa_data = vecs[i].wd;
            rd_addr = {vecs[i].r1, vecs[i].r0};
            sb_push(vecs[i].e0, vecs[i].e1);
            tick;
            sb_pop($sformatf("vec%0d", i));
        end
        idle;

        // Reset mid-RUN with x3 pending and a write in flight, then again mid-clear.
        rd_addr = {5'd0, 5'd3};
        sb_set = 1'b1; sb_addr = 5'd3;
        tick;
        idle;
        #1 chk("x3_pending", 32'(hazard[0]), 32'd1);
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h77;
        rstn = 1'b0;
        #1 chk("rst_run_wb_ready", 32'(wb_ready), 32'd0);
        chk("rst_run_busy", 32'(busy), 32'd1);
        tick; tick;
        idle;
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        rstn = 1'b0;
        #1 chk("rst_clear_busy", 32'(busy), 32'd1);
        tick;
        chk("rst_clear_busy2", 32'(busy), 32'd1);
        tick;
        rstn = 1'b1;
        count_clear(n, bad);
        chk("reclear_cycles", n, 32'd32);
        chk("reclear_outputs_quiet", bad, 32'd0);
        rd_addr = {5'd5, 5'd3};
        #1 chk("x3_hazard_after_reset", 32'(hazard[0]), 32'd0);
        sb_push(32'd0, 32'd0);
        tick;
        sb_pop("after_reclear");

        // Random traffic against a reference array; secondary requests held until taken.
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        wb_hold = 1'b0;
        wba = '0; wbd = '0;
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            if (!wb_hold) begin
                wbv = 1'($urandom_range(0, 1));
                wba = 5'($urandom_range(0, 31));
                wbd = $urandom;
            end else begin
                wbv = 1'b1;
            end
            r0 = 5'($urandom_range(0, 31));
            r1 = 5'($urandom_range(0, 31));
            acc = wbv && !we;
            e0 = (r0 == 0) ? 32'd0 : (we && wa == r0) ? wd : (acc && wba == r0) ? wbd : model_mem[r0];
            e1 = (r1 == 0) ? 32'd0 : (we && wa == r1) ? wd : (acc && wba == r1) ? wbd : model_mem[r1];
            n0 = (r0 == 0) ? 32'd0 : model_mem[r0];
            n1 = (r1 == 0) ? 32'd0 : model_mem[r1];
            wa_en = we; wa_addr = wa; wa_data = wd;
            wb_valid = wbv; wb_addr = wba; wb_data = wbd;
            rd_addr = {r1, r0};
            sb_push(e0, e1);
            #1 chk("rand_wb_ready", 32'(wb_ready), 32'(!we));
            tick;
            sb_pop("rand");
            chk("rand_nb_p0", rd_data_nb[31:0], n0);
            chk("rand_nb_p1", rd_data_nb[63:32], n1);
            if (we && wa != 0) model_mem[wa] = wd;
            else if (acc && wba != 0) model_mem[wba] = wbd;
            wb_hold = wbv && !acc;
        end
        idle;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
